// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, loadable instruction memory and the
// IF/ID pipeline register, with jump/branch redirects and decode back-pressure.
module fetch_stage #(
   parameter int unsigned      PC_W     = 5,
   parameter int unsigned      DATA_W   = 32,
   parameter int unsigned      DEPTH    = 2**PC_W,
   parameter logic [PC_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              im_we,
   input  logic [PC_W-1:0]   im_waddr,
   input  logic [DATA_W-1:0] im_wdata,
   input  logic              out_ready,
   input  logic              branch_taken,
   input  logic [PC_W-1:0]   br_pc,
   input  logic [15:0]       br_off,
   input  logic              jump,
   input  logic [25:0]       jump_target,
   output logic [PC_W-1:0]   pc,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_instr,
   output logic [PC_W-1:0]   if_pc,
   output logic [15:0]       fetch_count
);

   // Branch arithmetic width: wide enough for the sign-extended imm16 and PC_W+1 bits.
   localparam int unsigned AW = (PC_W + 1 > 17) ? PC_W + 1 : 17;

   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

   logic              rd_hit;
   logic              wr_hit;
   logic [DATA_W-1:0] rd_word;
   logic [PC_W-1:0]   br_tgt;
   logic [PC_W-1:0]   jmp_tgt;
   logic              adv;
   logic              unused_jump_hi;

   if (DEPTH >= 2**PC_W) begin : g_full
      assign rd_hit = 1'b1;
      assign wr_hit = 1'b1;
   end else begin : g_part
      assign rd_hit = (32'(pc) < DEPTH);
      assign wr_hit = (32'(im_waddr) < DEPTH);
   end

   assign rd_word        = rd_hit ? mem[pc] : '0;
   assign br_tgt         = PC_W'(AW'(br_pc) + AW'(1) + AW'($signed(br_off)));
   assign jmp_tgt        = jump_target[PC_W-1:0];
   assign unused_jump_hi = ^jump_target;

   // Handshake: IF/ID holds an instruction while if_valid=1; decode takes it on a
   // posedge with out_ready=1. An empty register (if_valid=0) always refills.
   assign adv = !if_valid || out_ready;

   // Program load port; not reset, so a program can be loaded while reset is held.
   always_ff @(posedge clk) begin
      if (im_we && wr_hit) begin
         mem[im_waddr] <= im_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc          <= RESET_PC;
         if_valid    <= 1'b0;
         if_instr    <= '0;
         if_pc       <= '0;
         fetch_count <= '0;
      end else if (jump) begin
         pc       <= jmp_tgt;
         if_valid <= 1'b0;
      end else if (branch_taken) begin
         pc       <= br_tgt;
         if_valid <= 1'b0;
      end else if (adv) begin
         if_instr <= rd_word;
         if_pc    <= pc;
         if_valid <= 1'b1;
         pc       <= pc + PC_W'(1);
         if (fetch_count != 16'hFFFF) begin
            fetch_count <= fetch_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, redirects, wrap,
// out-of-range reads, write/fetch collision and asynchronous reset.
module tb_fetch_stage;

   localparam int PC_W   = 5;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 28;

   // clock/reset block
   logic              clk = 1'b0;
   logic              reset;
   logic              im_we;
   logic [PC_W-1:0]   im_waddr;
   logic [DATA_W-1:0] im_wdata;
   logic              out_ready;
   logic              branch_taken;
   logic [PC_W-1:0]   br_pc;
   logic [15:0]       br_off;
   logic              jump;
   logic [25:0]       jump_target;
   logic [PC_W-1:0]   pc;
   logic              if_valid;
   logic [DATA_W-1:0] if_instr;
   logic [PC_W-1:0]   if_pc;
   logic [15:0]       fetch_count;

   always #5 clk = ~clk;

   fetch_stage #(.PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
      .clk(clk), .reset(reset),
      .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
      .out_ready(out_ready),
      .branch_taken(branch_taken), .br_pc(br_pc), .br_off(br_off),
      .jump(jump), .jump_target(jump_target),
      .pc(pc), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .fetch_count(fetch_count)
   );

   // scoreboard
   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_mem(input logic [PC_W-1:0] a, input logic [DATA_W-1:0] d);
      im_we    = 1'b1;
      im_waddr = a;
      im_wdata = d;
      tick();
      im_we    = 1'b0;
   endtask

   task automatic do_jump(input logic [25:0] t);
      jump        = 1'b1;
      jump_target = t;
      tick();
      jump        = 1'b0;
   endtask

   task automatic check_state(input string tag, input logic [PC_W-1:0] e_pc,
                              input logic e_v, input logic [31:0] e_instr,
                              input logic [PC_W-1:0] e_ipc, input logic [15:0] e_cnt);
      check({tag, ".pc"},    32'(pc),          32'(e_pc));
      check({tag, ".valid"}, 32'(if_valid),    32'(e_v));
      check({tag, ".instr"}, if_instr,         e_instr);
      check({tag, ".if_pc"}, 32'(if_pc),       32'(e_ipc));
      check({tag, ".count"}, 32'(fetch_count), 32'(e_cnt));
   endtask

   initial begin
      reset = 1'b0; im_we = 1'b0; im_waddr = '0; im_wdata = '0;
      out_ready = 1'b0; branch_taken = 1'b0; br_pc = '0; br_off = '0;
      jump = 1'b0; jump_target = '0;
      #2;
      check_state("reset", 5'd0, 1'b0, 32'h0, 5'd0, 16'd0);

      // program load while reset is held
      write_mem(5'd0,  32'h11);
      write_mem(5'd1,  32'h22);
      write_mem(5'd2,  32'h33);
      write_mem(5'd3,  32'h44);
      write_mem(5'd4,  32'h4444);
      write_mem(5'd5,  32'h55);
      write_mem(5'd7,  32'h77);
      write_mem(5'd27, 32'hDEAD_0027);
      write_mem(5'd29, 32'hBAD0_0029);
      check("held_in_reset.pc", 32'(pc), 32'd0);

      // sequential fetch 0..3
      out_ready = 1'b1;
      reset     = 1'b1;
      exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
      for (int i = 0; i < 4; i++) begin
         tick();
         check("seq.instr", if_instr, exp_q.pop_front());
         check("seq.if_pc", 32'(if_pc), 32'(i));
         check("seq.valid", 32'(if_valid), 32'd1);
      end
      check_state("seq_end", 5'd4, 1'b1, 32'h44, 5'd3, 16'd4);

      // decode stall for 3 cycles, then resume at held pc
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_state("stall", 5'd4, 1'b1, 32'h44, 5'd3, 16'd4);
      end
      out_ready = 1'b1;
      tick();
      check_state("resume", 5'd5, 1'b1, 32'h4444, 5'd4, 16'd5);

      // taken branch backwards: 4 + 1 - 3 = 2
      branch_taken = 1'b1; br_pc = 5'd4; br_off = 16'hFFFD;
      tick();
      branch_taken = 1'b0;
      check_state("br_back", 5'd2, 1'b0, 32'h4444, 5'd4, 16'd5);
      tick();
      check_state("br_back_fetch", 5'd3, 1'b1, 32'h33, 5'd2, 16'd6);

      // branch wraps 31 + 1 + 1 = 1, honoured while out_ready=0
      branch_taken = 1'b1; br_pc = 5'd31; br_off = 16'h0001; out_ready = 1'b0;
      tick();
      branch_taken = 1'b0;
      check_state("br_wrap", 5'd1, 1'b0, 32'h33, 5'd2, 16'd6);
      tick();
      check_state("refill_no_ready", 5'd2, 1'b1, 32'h22, 5'd1, 16'd7);
      tick();
      check_state("stall2", 5'd2, 1'b1, 32'h22, 5'd1, 16'd7);
      out_ready = 1'b1;

      // jump beats simultaneous branch
      branch_taken = 1'b1; br_pc = 5'd0; br_off = 16'h0000;
      do_jump(26'h0000007);
      branch_taken = 1'b0;
      check_state("jump_wins", 5'd7, 1'b0, 32'h22, 5'd1, 16'd7);
      tick();
      check_state("jump_fetch", 5'd8, 1'b1, 32'h77, 5'd7, 16'd8);

      // pc wrap 30,31,0,1 (30/31 are beyond DEPTH and read 0)
      do_jump(26'h000001E);
      check("wrap_jump.pc", 32'(pc), 32'd30);
      exp_q = '{32'h0, 32'h0, 32'h11, 32'h22};
      for (int i = 0; i < 4; i++) begin
         tick();
         check("wrap.if_pc", 32'(if_pc), 32'((30 + i) % 32));
         check("wrap.instr", if_instr, exp_q.pop_front());
      end
      check_state("wrap_end", 5'd2, 1'b1, 32'h22, 5'd1, 16'd12);

      // DEPTH boundary: 27 is last valid word, 28 reads 0
      do_jump(26'h000001B);
      tick();
      check_state("last_word", 5'd28, 1'b1, 32'hDEAD_0027, 5'd27, 16'd13);
      tick();
      check_state("past_depth", 5'd29, 1'b1, 32'h0, 5'd28, 16'd14);

      // write and fetch same address in one cycle: old data captured
      do_jump(26'h0000005);
      im_we = 1'b1; im_waddr = 5'd5; im_wdata = 32'hAA;
      tick();
      im_we = 1'b0;
      check_state("wr_collide", 5'd6, 1'b1, 32'h55, 5'd5, 16'd15);
      do_jump(26'h0000005);
      tick();
      check_state("wr_new", 5'd6, 1'b1, 32'hAA, 5'd5, 16'd16);

      // asynchronous reset in the middle of a stall
      out_ready = 1'b0;
      tick();
      check_state("pre_reset_stall", 5'd6, 1'b1, 32'hAA, 5'd5, 16'd16);
      #2;
      reset = 1'b0;
      #1;
      check_state("async_reset", 5'd0, 1'b0, 32'h0, 5'd0, 16'd0);

      // reset dominates jump and fetch
      out_ready = 1'b1;
      jump = 1'b1; jump_target = 26'h0000009;
      tick();
      jump = 1'b0;
      check_state("reset_dominates", 5'd0, 1'b0, 32'h0, 5'd0, 16'd0);

      // final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Parametrised instruction-fetch stage for the single-cycle/pipelined MIPS-style datapath.
- Holds the program counter, an internal loadable instruction memory and the IF/ID pipeline register.
- Supports sequential fetch, taken-branch and jump redirects, and decode back-pressure.
- Feeds the decode stage (register-file address extraction, control unit, sign extend).

Parameters:
- PC_W, 5, PC / instruction-memory address width in words (1..26).
- DATA_W, 32, instruction width.
- DEPTH, 2**PC_W, instruction-memory words; addresses at or above DEPTH read as 0.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- im_we  input  1  instruction-memory write enable (program load).
- im_waddr  input  PC_W  write word address.
- im_wdata  input  DATA_W  write data.
- out_ready  input  1  decode accepts the IF/ID contents this cycle.
- branch_taken  input  1  taken-branch redirect request from execute.
- br_pc  input  PC_W  PC of the branch instruction.
- br_off  input  16  signed word offset (the instruction's imm16).
- jump  input  1  jump redirect request.
- jump_target  input  26  jump field (instr[25:0]).
- pc  output  PC_W  current fetch PC.
- if_valid  output  1  IF/ID holds a valid instruction.
- if_instr  output  DATA_W  registered instruction.
- if_pc  output  PC_W  PC of if_instr.
- fetch_count  output  16  count of instructions accepted into IF/ID; saturates at 16'hFFFF.

Behaviour:
- Reset (reset=0, asynchronous, any time): pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, fetch_count=0.
  - Instruction memory is not reset; it initialises to all zero at time 0.
  - Reset dominates every other input.
- Memory read: asynchronous, mem[pc]; out-of-range address returns 0.
- Memory write: on posedge when im_we=1.
  - A fetch of the same address in the same cycle captures the OLD data.
  - A write to an address >= DEPTH is ignored.
- Advance condition: adv = !if_valid || out_ready.
- Per-posedge priority (highest first):
  1. jump=1: pc <= jump_target[PC_W-1:0]; if_valid <= 0 (wrong-path kill); if_instr and if_pc hold; fetch_count holds.
  2. branch_taken=1 (jump=0): pc <= br_pc + 1 + sext(br_off), truncated mod 2^PC_W; if_valid <= 0; no count.
  3. adv=1: if_instr <= mem[pc]; if_pc <= pc; if_valid <= 1; pc <= pc+1 mod 2^PC_W (wraps from all-ones to 0); fetch_count++ (saturating).
  4. Otherwise (stall: if_valid=1, out_ready=0): all state holds.
- Redirects are honoured regardless of out_ready.
- Simultaneous jump and branch_taken: jump wins.
- Latency: the instruction at PC p appears on if_instr with if_valid=1 one cycle after pc==p and adv=1. Back-to-back fetch sustains 1 instruction/cycle with out_ready=1.
- After a redirect, the first target instruction is valid 2 cycles after the redirect edge's cycle: the redirect edge, then the fetch edge.
- Outputs are registered; no combinational path from out_ready, branch_taken or jump to any output.
- Arithmetic: sext(br_off) is extended to at least PC_W+1 bits before the add; the result is truncated to PC_W bits with no overflow flag.

Test Plan:
- Reset, load mem[0..3]=32'h11,22,33,44, release reset, out_ready=1 → if_instr 32'h11,22,33,44 on consecutive cycles; if_pc 0,1,2,3; fetch_count=4.
- PC_W=5, run from pc=30 with out_ready=1 → if_pc 30,31,0,1: wrap with no glitch.
- if_valid=1, out_ready=0 for 3 cycles → pc, if_instr, if_pc and fetch_count frozen; release → fetch resumes at the held pc.
- branch_taken with br_pc=4, br_off=16'hFFFD (-3) → pc=2 next edge, if_valid=0 that cycle, then if_instr=mem[2]. br_pc=31, br_off=+1 → pc=1 (wrap).
- jump=1 and branch_taken=1 in the same cycle, jump_target=26'h0000007, PC_W=5 → pc=7; the branch is ignored.
- im_we writing addr 5 while pc=5 → the old word is captured; the next fetch of 5 returns the new word. Assert reset mid-stall → all outputs 0 and pc=RESET_PC immediately, without waiting for clk.
